funnel_arb: RTL

Round-robin arbiter sharing one funnel target port (`t_0_req`/`t_0_ack`, `mode`, `t_cfg_req`/`t_cfg_ack`) among `SOURCES` upstream streams. Grants are burst-locked: a winner holds the funnel for its declared beat count. The funnel mode is reconfigured between bursts only when the winner's mode differs from the one currently applied. Sits directly upstream of the funnel controller; `gnt` drives the wide-data mux in front of the funnel.

---
 rtl/funnel_pkg.sv | 18 +
 rtl/funnel_arb_if.sv | 28 ++
 rtl/funnel_rr_pick.sv | 34 +++
 rtl/funnel_arb.sv | 120 ++++++++++++
 4 files changed

// File: rtl/funnel_pkg.sv
// Shared types and constants for the funnel round-robin arbiter.
package funnel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int unsigned MODE_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 8;

    // Funnel reduction modes
    localparam logic [7:0] MODE_8TO4 = 8'h01;
    localparam logic [7:0] MODE_8TO2 = 8'h02;
    localparam logic [7:0] MODE_8TO1 = 8'h04;

endpackage

// File: rtl/funnel_arb_if.sv
// Handshake bundle between upstream sources, the arbiter and the funnel target.
interface funnel_arb_if #(
    parameter int unsigned SOURCES = 4,
    parameter int unsigned MODE_W  = 8,
    parameter int unsigned LEN_W   = 8
);
    logic [SOURCES-1:0]        s_req;
    logic [SOURCES-1:0]        s_ack;
    logic [SOURCES*MODE_W-1:0] s_mode;
    logic [SOURCES*LEN_W-1:0]  s_len;
    logic                      t_0_req;
    logic                      t_0_ack;
    logic [MODE_W-1:0]         mode;
    logic                      t_cfg_req;
    logic                      t_cfg_ack;
    logic [SOURCES-1:0]        gnt;
    logic                      busy;

    modport master (
        input  s_req, s_mode, s_len, t_0_ack, t_cfg_ack,
        output s_ack, t_0_req, mode, t_cfg_req, gnt, busy
    );

    modport slave (
        output s_req, s_mode, s_len, t_0_ack, t_cfg_ack,
        input  s_ack, t_0_req, mode, t_cfg_req, gnt, busy
    );
endinterface

// File: rtl/funnel_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module funnel_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    logic           found;

    // Low half holds only requesters above ptr, so it wins before the wrapped copy
    always_comb begin
        masked = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < int'(N); i++) begin
            masked[i] = req[i] && (IW'(i) > ptr);
        end
        dbl = {req, masked};
        for (int i = 0; i < int'(2 * N); i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx   = IW'(i % int'(N));
            end
        end
        win = found ? (N'(1) << idx) : '0;
        any = found;
    end
endmodule

// File: rtl/funnel_arb.sv
// Burst-locked round-robin arbiter in front of the funnel; reconfigures mode between bursts.
module funnel_arb
    import funnel_pkg::*;
#(
    parameter int unsigned SOURCES = 4,
    parameter int unsigned MODE_W  = MODE_W_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    funnel_arb_if.master bus
);
    localparam int unsigned IW = $clog2(SOURCES);

    state_t             state;
    logic [SOURCES-1:0] gnt_q;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      ptr;
    logic [MODE_W-1:0]  mode_q;
    logic               cfg_q;
    logic               busy_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;

    logic [SOURCES-1:0] win;
    logic [IW-1:0]      widx;
    logic               any;
    logic [MODE_W-1:0]  sel_mode;
    logic [LEN_W-1:0]   sel_len;
    logic               in_xfer;
    logic               t0;
    logic               beat;
    logic               last;

    funnel_rr_pick #(.N(SOURCES), .IW(IW)) u_pick (
        .req (bus.s_req),
        .ptr (ptr),
        .win (win),
        .idx (widx),
        .any (any)
    );

    // Winner's mode and length, sampled only at grant
    always_comb begin
        sel_mode = '0;
        sel_len  = '0;
        for (int i = 0; i < int'(SOURCES); i++) begin
            if (widx == IW'(i)) begin
                sel_mode = bus.s_mode[i*MODE_W +: MODE_W];
                sel_len  = bus.s_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign in_xfer = (state == XFER);
    assign t0      = in_xfer & (|(gnt_q & bus.s_req));
    assign beat    = t0 & bus.t_0_ack;
    // len 0 wraps to all-ones, giving 2^LEN_W beats
    assign last    = (cnt == LEN_W'(len_q - LEN_W'(1)));

    assign bus.t_0_req   = t0;
    assign bus.s_ack     = gnt_q & bus.s_req & {SOURCES{in_xfer & bus.t_0_ack}};
    assign bus.gnt       = gnt_q;
    assign bus.mode      = mode_q;
    assign bus.t_cfg_req = cfg_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            gnt_q  <= '0;
            gidx   <= '0;
            ptr    <= IW'(SOURCES - 1);
            mode_q <= '0;
            cfg_q  <= 1'b0;
            busy_q <= 1'b0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt_q  <= win;
                        gidx   <= widx;
                        len_q  <= sel_len;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        if (sel_mode != mode_q) begin
                            mode_q <= sel_mode;
                            cfg_q  <= 1'b1;
                            state  <= CFG;
                        end else begin
                            state  <= XFER;
                        end
                    end
                end
                CFG: begin
                    if (bus.t_cfg_ack) begin
                        cfg_q <= 1'b0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (last) begin
                            ptr    <= gidx;
                            gnt_q  <= '0;
                            cnt    <= '0;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
